mmem_responder: RTL and testbench
=================================

# mmem_responder

Byte-wide main-memory responder at the far end of the memory controller's bus. Accepts one byte read or write per cycle on `mmem_r_w`/`mmem_addr`/`mmem_data` and returns read bytes on `data_get` one cycle later. Decodes a small memory-mapped I/O window that moves bytes to and from a host serial link through TX/RX FIFOs, and provides a simulation halt flag. Sits between `memctrl` and the top level/host, replacing a bare RAM.

## Interface
- ADDR_WIDTH, 17, RAM index width; the RAM holds 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 8, entries per I/O FIFO; must be a power of 2, ≥2.
- INIT_FILE, "", hex image loaded at elaboration; an empty string means no preload.
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  access qualifier; tied to 1 when driven by memctrl
- mmem_r_w  in  1  0 = read, 1 = write
- mmem_addr  in  32  byte address
- mmem_data  in  8  write byte
- data_get  out  8  read byte, registered
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  host consumes tx_data when tx_valid && tx_ready
- rx_data  in  8  host byte
- rx_valid  in  1  host offers rx_data
- rx_ready  out  1  RX FIFO not full
- halt  out  1  sticky, set by write to HALT
- tx_overflow  out  1  sticky, TX write dropped because FIFO full

## Operation
- Decode: `mmem_addr[17:16]==2'b11` selects I/O space; otherwise RAM at index `mmem_addr[ADDR_WIDTH-1:0]`. Upper address bits are ignored.
- I/O registers (byte addresses):
  - 0x30000 read: RX head byte (non-destructive peek), 0x00 if empty. Write: push byte to TX FIFO.
  - 0x30004 read: status {5'b0, halt, rx_nonempty, tx_full}. Write: set `halt`, data ignored.
  - 0x30008 write: pop RX FIFO (no-op if empty). Read returns 0x00.
  - Other I/O addresses: reads return 0x00, writes are ignored.
- RAM write: when `en && mmem_r_w`, `ram[idx] <= mmem_data`.
- Read: when `en && !mmem_r_w`, `data_get <= selected byte`. When `en==0`, `data_get` holds its value. Reads have no side effects.
- TX FIFO:
  - Push on I/O write to 0x30000; pop on `tx_valid && tx_ready`.
  - A push while full is dropped and sets `tx_overflow`, unless a pop happens in the same cycle. In that case the push is accepted and the count is unchanged.
- RX FIFO: push on `rx_valid && rx_ready`; pop on write to 0x30008. A simultaneous push and pop is legal at any fill level.
- `halt` and `tx_overflow` clear only on `rst`.

## Timing
- Read latency 1: address presented in cycle N gives `data_get` valid after edge N+1. This holds for back-to-back reads at consecutive addresses, one byte per cycle, as memctrl issues them.
- Read-after-write to the same address in consecutive cycles returns the new byte. A read in the same cycle as a write to the same address returns the old byte.
- Status and FIFO state read in cycle N reflect register values before edge N. Push/pop effects become visible to reads in cycle N+1.
- `tx_valid` and `rx_ready` are derived combinationally from registered FIFO counts. `tx_data` is the registered head.
- Reset values: `data_get`=0, `tx_valid`=0, `rx_ready`=1, `halt`=0, `tx_overflow`=0, FIFO pointers and counts=0.
- RAM contents are not affected by `rst`, including a reset mid-transfer.
- A reset asserted in the same cycle as a write suppresses any I/O effect of that write. Whether a RAM write in that cycle completes is unspecified.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits. The count is log2(FIFO_DEPTH)+1 bits, ranging 0..FIFO_DEPTH.

## Structure
- `defines.v` gains `IO_RXTX_ADDR` 32'h30000, `IO_STAT_ADDR` 32'h30004, and `IO_RXPOP_ADDR` 32'h30008.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated twice.
- RAM is an inferred `reg [7:0]` array, preloaded with `$readmemh` when INIT_FILE is non-empty.

## Test plan
- INIT_FILE has bytes 13,00,00,00 at 0x0; read addresses 0..3 on consecutive cycles → `data_get` shows 0x13, 0x00, 0x00, 0x00 on cycles 1..4.
- Write 0xAB to 0x100 in cycle N, read 0x100 in cycle N+1 → `data_get`=0xAB after edge N+2.
- Hold `tx_ready`=0 and write 9 bytes to 0x30000 → the first 8 are queued, `tx_overflow`=1, status bit0=1. Then raise `tx_ready` → the 8 bytes drain in order, and `tx_valid` falls after the 8th.
- With the TX FIFO full, write 0x30000 while `tx_ready`=1 in the same cycle → byte accepted, `tx_overflow` stays 0.
- Host pushes 0x41, 0x42; read 0x30000 twice → 0x41 both times. Write 0x30008, then read → 0x42. Pop again, then read status → bit1=0.
- Write to 0x30004 → `halt`=1 next cycle. Assert `rst` → `halt`=0 and `data_get`=0, and a RAM byte written earlier still reads back.

Source files
------------

// File: rtl/mmem_responder_pkg.sv
// Shared constants and helpers for the main-memory responder: I/O register map and its decoder.
package mmem_responder_pkg;

   localparam logic [31:0] IO_RXTX_ADDR  = 32'h0003_0000;
   localparam logic [31:0] IO_STAT_ADDR  = 32'h0003_0004;
   localparam logic [31:0] IO_RXPOP_ADDR = 32'h0003_0008;

   typedef enum logic [1:0] {
      IO_NONE,
      IO_RXTX,
      IO_STAT,
      IO_RXPOP
   } io_reg_e;

   // Only the low 18 address bits take part in I/O decode; everything above aliases.
   function automatic io_reg_e decodeIo(input logic [17:0] addr);
      if (addr == IO_RXTX_ADDR[17:0])  return IO_RXTX;
      if (addr == IO_STAT_ADDR[17:0])  return IO_STAT;
      if (addr == IO_RXPOP_ADDR[17:0]) return IO_RXPOP;
      return IO_NONE;
   endfunction

endpackage

// File: rtl/mmem_responder_fifo.sv
// Small synchronous FIFO used for the host TX and RX byte queues.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW:0]      count_q, count_d;
   logic             doPush, doPop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (PW+1)'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rdPtr_q];

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + PW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
      if (doPush && !doPop)      count_d = count_q + (PW+1)'(1);
      else if (doPop && !doPush) count_d = count_q - (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= din;
   end

endmodule

// File: rtl/mmem_responder.sv
// Byte-wide main-memory responder: RAM plus a tiny I/O window bridging to host TX/RX FIFOs and a halt flag.
module mmem_responder
   import mmem_responder_pkg::*;
#(
   parameter int    ADDR_WIDTH = 17,
   parameter int    FIFO_DEPTH = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        mmem_r_w,
   input  logic [31:0] mmem_addr,
   input  logic [7:0]  mmem_data,
   output logic [7:0]  data_get,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        halt,
   output logic        tx_overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0] ram [2**ADDR_WIDTH];

   logic [ADDR_WIDTH-1:0] ramIdx;
   logic                  ioSel, ioWrite;
   io_reg_e               ioReg;
   logic                  txPush, txPop, txFull, txEmpty;
   logic                  rxPush, rxPop, rxFull, rxEmpty;
   logic [7:0]            rxHead, readByte;
   logic [CW-1:0]         unusedTxCount, unusedRxCount;
   logic                  unusedAddr;
   logic [7:0]            dataGet_q, dataGet_d;
   logic                  halt_q, halt_d;
   logic                  txOverflow_q, txOverflow_d;

   assign unusedAddr = ^mmem_addr[31:18];
   assign ramIdx     = mmem_addr[ADDR_WIDTH-1:0];
   assign ioSel      = (mmem_addr[17:16] == 2'b11);
   assign ioReg      = ioSel ? decodeIo(mmem_addr[17:0]) : IO_NONE;

   // Reset masks every I/O side effect of a write issued in the same cycle.
   assign ioWrite = en && mmem_r_w && !rst;
   assign txPush  = ioWrite && (ioReg == IO_RXTX);
   assign rxPop   = ioWrite && (ioReg == IO_RXPOP);
   assign txPop   = tx_valid && tx_ready;
   assign rxPush  = rx_valid && rx_ready;

   assign tx_valid    = !txEmpty;
   assign rx_ready    = !rxFull;
   assign data_get    = dataGet_q;
   assign halt        = halt_q;
   assign tx_overflow = txOverflow_q;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
      .clk(clk), .rst(rst), .push(txPush), .pop(txPop), .din(mmem_data),
      .dout(tx_data), .full(txFull), .empty(txEmpty), .count(unusedTxCount)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxFifo (
      .clk(clk), .rst(rst), .push(rxPush), .pop(rxPop), .din(rx_data),
      .dout(rxHead), .full(rxFull), .empty(rxEmpty), .count(unusedRxCount)
   );

   always_comb begin
      readByte = 8'h00;
      if (!ioSel) begin
         readByte = ram[ramIdx];
      end else begin
         case (ioReg)
            IO_RXTX: readByte = rxEmpty ? 8'h00 : rxHead;
            IO_STAT: readByte = {5'b0, halt_q, !rxEmpty, txFull};
            default: readByte = 8'h00;
         endcase
      end
   end

   always_comb begin
      dataGet_d    = dataGet_q;
      halt_d       = halt_q;
      txOverflow_d = txOverflow_q;
      if (en && !mmem_r_w)                  dataGet_d    = readByte;
      if (ioWrite && (ioReg == IO_STAT))    halt_d       = 1'b1;
      if (txPush && txFull && !txPop)       txOverflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dataGet_q    <= 8'h00;
         halt_q       <= 1'b0;
         txOverflow_q <= 1'b0;
      end else begin
         dataGet_q    <= dataGet_d;
         halt_q       <= halt_d;
         txOverflow_q <= txOverflow_d;
      end
   end

   // RAM has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (en && mmem_r_w && !ioSel) ram[ramIdx] <= mmem_data;
   end

endmodule

// File: tb/tb_mmem_responder.sv
// Directed self-checking bench for mmem_responder: RAM access, TX/RX FIFO windows, halt and reset behaviour.
module tb_mmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        mmem_r_w;
   logic [31:0] mmem_addr;
   logic [7:0]  mmem_data;
   logic [7:0]  data_get;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        halt;
   logic        tx_overflow;

   int checks = 0;
   int errors = 0;

   mmem_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8), .INIT_FILE("")) dut (
      .clk(clk), .rst(rst), .en(en), .mmem_r_w(mmem_r_w), .mmem_addr(mmem_addr),
      .mmem_data(mmem_data), .data_get(data_get), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .halt(halt), .tx_overflow(tx_overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One bus access lasting exactly one clock; returns 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [7:0] data);
      en        = 1'b1;
      mmem_r_w  = rw;
      mmem_addr = addr;
      mmem_data = data;
      @(posedge clk); #1;
      en        = 1'b0;
      mmem_r_w  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mmem_r_w = 1'b0; mmem_addr = '0; mmem_data = '0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      tick(); tick();
      checkOutput("rstDataGet", data_get, 8'h00);
      checkOutput("rstTxValid", tx_valid, 1'b0);
      checkOutput("rstRxReady", rx_ready, 1'b1);
      checkOutput("rstHalt", halt, 1'b0);
      checkOutput("rstTxOverflow", tx_overflow, 1'b0);
      rst = 1'b0;

      // Image 13,00,00,00 at address 0, then a back-to-back burst read.
      applyStimulus(1'b1, 32'h0, 8'h13);
      applyStimulus(1'b1, 32'h1, 8'h00);
      applyStimulus(1'b1, 32'h2, 8'h00);
      applyStimulus(1'b1, 32'h3, 8'h00);
      applyStimulus(1'b0, 32'h0, 8'h00); checkOutput("burst0", data_get, 8'h13);
      applyStimulus(1'b0, 32'h1, 8'h00); checkOutput("burst1", data_get, 8'h00);
      applyStimulus(1'b0, 32'h2, 8'h00); checkOutput("burst2", data_get, 8'h00);
      applyStimulus(1'b0, 32'h3, 8'h00); checkOutput("burst3", data_get, 8'h00);

      applyStimulus(1'b1, 32'h100, 8'hAB);
      applyStimulus(1'b0, 32'h100, 8'h00); checkOutput("readAfterWrite", data_get, 8'hAB);
      mmem_addr = 32'h0;
      tick(); checkOutput("holdWhenIdle", data_get, 8'hAB);
      applyStimulus(1'b0, 32'h0, 8'h00); checkOutput("reread0", data_get, 8'h13);
      applyStimulus(1'b0, 32'hFFFC_0100, 8'h00); checkOutput("upperBitsAlias", data_get, 8'hAB);
      applyStimulus(1'b0, 32'h3000C, 8'h00); checkOutput("unmappedIo", data_get, 8'h00);

      // Overflow: nine pushes with the host stalled, then drain.
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h30000, 8'(8'h50 + i));
      checkOutput("ovfFlag", tx_overflow, 1'b1);
      checkOutput("ovfTxValid", tx_valid, 1'b1);
      checkOutput("ovfHead", tx_data, 8'h50);
      applyStimulus(1'b0, 32'h30004, 8'h00); checkOutput("ovfStatus", data_get, 8'h01);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("drainValid", tx_valid, 1'b1);
         checkOutput("drainData", tx_data, 32'h50 + i);
         tick();
      end
      checkOutput("drainEmpty", tx_valid, 1'b0);
      tx_ready = 1'b0;
      pulseReset();
      checkOutput("ovfCleared", tx_overflow, 1'b0);

      // Push into a full FIFO while the host pops in the same cycle.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h30000, 8'(8'h70 + i));
      checkOutput("fullNoOvf", tx_overflow, 1'b0);
      tx_ready = 1'b1;
      applyStimulus(1'b1, 32'h30000, 8'h78);
      checkOutput("pushPopOvf", tx_overflow, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("pushPopData", tx_data, 32'h71 + i);
         tick();
      end
      checkOutput("pushPopEmpty", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // RX window: peek, pop, status.
      applyStimulus(1'b0, 32'h30000, 8'h00); checkOutput("rxEmptyRead", data_get, 8'h00);
      rx_valid = 1'b1; rx_data = 8'h41; tick();
      rx_data = 8'h42; tick();
      rx_valid = 1'b0;
      applyStimulus(1'b0, 32'h30000, 8'h00); checkOutput("rxPeek1", data_get, 8'h41);
      applyStimulus(1'b0, 32'h30000, 8'h00); checkOutput("rxPeek2", data_get, 8'h41);
      applyStimulus(1'b0, 32'h30008, 8'h00); checkOutput("rxPopRead", data_get, 8'h00);
      applyStimulus(1'b1, 32'h30008, 8'h00);
      applyStimulus(1'b0, 32'h30000, 8'h00); checkOutput("rxAfterPop", data_get, 8'h42);
      applyStimulus(1'b0, 32'h30004, 8'h00); checkOutput("rxStatusNonEmpty", data_get, 8'h02);
      applyStimulus(1'b1, 32'h30008, 8'h00);
      applyStimulus(1'b0, 32'h30004, 8'h00); checkOutput("rxStatusEmpty", data_get, 8'h00);
      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'(8'h90 + i);
         tick();
      end
      rx_valid = 1'b0;
      checkOutput("rxFullReady", rx_ready, 1'b0);
      applyStimulus(1'b0, 32'h30000, 8'h00); checkOutput("rxFullHead", data_get, 8'h90);
      applyStimulus(1'b1, 32'h30008, 8'h00);
      checkOutput("rxReadyAfterPop", rx_ready, 1'b1);

      // Halt and reset.
      applyStimulus(1'b1, 32'h30004, 8'h00);
      checkOutput("haltSet", halt, 1'b1);
      applyStimulus(1'b0, 32'h30004, 8'h00); checkOutput("haltStatus", data_get, 8'h06);
      pulseReset();
      checkOutput("haltCleared", halt, 1'b0);
      checkOutput("resetDataGet", data_get, 8'h00);
      checkOutput("resetRxReady", rx_ready, 1'b1);
      applyStimulus(1'b0, 32'h100, 8'h00); checkOutput("ramSurvivesReset", data_get, 8'hAB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
